// File: rtl/commit_trace_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | commit_trace_writer: merges per-cycle commit events into an ordered trace  |
// | FIFO with sequence numbers and a trap-driven drain/halt FSM. Rev 1.0       |
// +----------------------------------------------------------------------------+
module commit_trace_writer #(
  parameter int DEPTH = 8,
  parameter int SEQW  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wb_valid,
  input  logic [31:0]                wb_pc,
  input  logic [31:0]                wb_instr,
  input  logic [31:0]                wb_data,
  input  logic [4:0]                 wb_rd,
  input  logic                       st_valid,
  input  logic [31:0]                st_pc,
  input  logic [31:0]                st_instr,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic                       br_valid,
  input  logic [31:0]                br_pc,
  input  logic [31:0]                br_instr,
  input  logic [31:0]                br_next_pc,
  input  logic                       trap_valid,
  input  logic [31:0]                trap_pc,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [1:0]                 rec_type,
  output logic [31:0]                rec_pc,
  output logic [31:0]                rec_instr,
  output logic [31:0]                rec_f0,
  output logic [31:0]                rec_f1,
  output logic [4:0]                 rec_rd,
  output logic [SEQW-1:0]            rec_seq,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]      typ;
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic [31:0]     f0;
    logic [31:0]     f1;
    logic [4:0]      rd;
    logic [SEQW-1:0] seq;
  } rec_t;

  rec_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [SEQW-1:0] seq;
  state_t          state, state_nxt;

  logic            running, q_wb, q_st, q_br, q_tr, pop, push, drop;
  logic [1:0]      ofs_st, ofs_br, ofs_tr;
  logic [2:0]      n_ev;
  logic [AW+1:0]   free;
  logic [AW-1:0]   a_wb, a_st, a_br, a_tr;
  rec_t            r_wb, r_st, r_br, r_tr, head;

  always_comb begin
    running = (state == RUN);
    q_wb    = running && wb_valid && (wb_rd != 5'd0);
    q_st    = running && st_valid;
    q_br    = running && br_valid;
    q_tr    = running && trap_valid;
    // Slot offset of each event = number of older qualifying events this cycle
    ofs_st  = {1'b0, q_wb};
    ofs_br  = ofs_st + {1'b0, q_st};
    ofs_tr  = ofs_br + {1'b0, q_br};
    n_ev    = {1'b0, ofs_tr} + {2'b00, q_tr};
    pop     = (count != '0) && rec_ready;
    free    = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);
    push    = (n_ev != 3'd0) && ((AW+2)'(n_ev) <= free);
    drop    = (n_ev != 3'd0) && !push;
    a_wb    = wr_ptr;
    a_st    = wr_ptr + AW'(ofs_st);
    a_br    = wr_ptr + AW'(ofs_br);
    a_tr    = wr_ptr + AW'(ofs_tr);

    r_wb = '{typ: 2'd0, pc: wb_pc, instr: wb_instr, f0: wb_data, f1: 32'd0,
             rd: wb_rd, seq: seq};
    r_st = '{typ: 2'd1, pc: st_pc, instr: st_instr, f0: st_addr, f1: st_data,
             rd: 5'd0, seq: seq + SEQW'(ofs_st)};
    r_br = '{typ: 2'd2, pc: br_pc, instr: br_instr, f0: br_next_pc, f1: 32'd0,
             rd: 5'd0, seq: seq + SEQW'(ofs_br)};
    r_tr = '{typ: 2'd3, pc: trap_pc, instr: 32'd0, f0: 32'd0, f1: 32'd0,
             rd: 5'd0, seq: seq + SEQW'(ofs_tr)};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (q_wb) mem[a_wb] <= r_wb;
      if (q_st) mem[a_st] <= r_st;
      if (q_br) mem[a_br] <= r_br;
      if (q_tr) mem[a_tr] <= r_tr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      state    <= RUN;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(n_ev);
        seq    <= seq + SEQW'(n_ev);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push ? n_ev : 3'd0) - (AW+1)'(pop);
      if (drop) overflow <= 1'b1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (push && q_tr) state_nxt = HALT;
      HALT:    if (count == '0) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  // Record outputs read as zero whenever the FIFO is empty
  always_comb begin
    rec_valid = (count != '0);
    head      = rec_valid ? mem[rd_ptr] : '0;
    rec_type  = head.typ;
    rec_pc    = head.pc;
    rec_instr = head.instr;
    rec_f0    = head.f0;
    rec_f1    = head.f1;
    rec_rd    = head.rd;
    rec_seq   = head.seq;
    occupancy = count;
    done      = (state == DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_writer.sv
`default_nettype none
// Self-checking bench for commit_trace_writer: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_commit_trace_writer;
  localparam int DEPTH = 8;
  localparam int SEQW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        wb_valid, st_valid, br_valid, trap_valid, rec_ready;
  logic [31:0] wb_pc, wb_instr, wb_data, st_pc, st_instr, st_addr, st_data;
  logic [31:0] br_pc, br_instr, br_next_pc, trap_pc;
  logic [4:0]  wb_rd;
  logic        rec_valid, overflow, done;
  logic [1:0]  rec_type;
  logic [31:0] rec_pc, rec_instr, rec_f0, rec_f1;
  logic [4:0]  rec_rd;
  logic [SEQW-1:0] rec_seq;
  logic [$clog2(DEPTH):0] occupancy;

  commit_trace_writer #(.DEPTH(DEPTH), .SEQW(SEQW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_data(wb_data), .wb_rd(wb_rd),
    .st_valid(st_valid), .st_pc(st_pc), .st_instr(st_instr), .st_addr(st_addr), .st_data(st_data),
    .br_valid(br_valid), .br_pc(br_pc), .br_instr(br_instr), .br_next_pc(br_next_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_type(rec_type), .rec_pc(rec_pc), .rec_instr(rec_instr), .rec_f0(rec_f0),
    .rec_f1(rec_f1), .rec_rd(rec_rd), .rec_seq(rec_seq),
    .occupancy(occupancy), .overflow(overflow), .done(done)
  );

  typedef struct {
    bit [1:0]      t;
    bit [31:0]     pc, instr, f0, f1;
    bit [4:0]      rd;
    bit [SEQW-1:0] seq;
  } mrec_t;

  mrec_t         mq[$];
  bit [SEQW-1:0] mseq;
  bit            movf, mhalt, mdone;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(rec_valid), 64'(mq.size() != 0));
    chk({tag, ".occ"}, 64'(occupancy), 64'(mq.size()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(movf));
    chk({tag, ".done"}, 64'(done), 64'(mdone));
    if (mq.size() != 0) begin
      chk({tag, ".type"}, 64'(rec_type), 64'(mq[0].t));
      chk({tag, ".pc"}, 64'(rec_pc), 64'(mq[0].pc));
      chk({tag, ".instr"}, 64'(rec_instr), 64'(mq[0].instr));
      chk({tag, ".f0"}, 64'(rec_f0), 64'(mq[0].f0));
      chk({tag, ".f1"}, 64'(rec_f1), 64'(mq[0].f1));
      chk({tag, ".rd"}, 64'(rec_rd), 64'(mq[0].rd));
      chk({tag, ".seq"}, 64'(rec_seq), 64'(mq[0].seq));
    end else begin
      chk({tag, ".empty_rec"}, {rec_type, rec_rd, rec_seq, rec_pc[7:0]}, 64'd0);
      chk({tag, ".empty_flds"}, {rec_instr ^ rec_f0, rec_f1}, 64'd0);
    end
  endtask

  function automatic mrec_t mk(input bit [1:0] t, input bit [31:0] pc, input bit [31:0] instr,
                               input bit [31:0] f0, input bit [31:0] f1, input bit [4:0] rd);
    mrec_t r;
    r.t = t; r.pc = pc; r.instr = instr; r.f0 = f0; r.f1 = f1; r.rd = rd; r.seq = '0;
    return r;
  endfunction

  task automatic idle_inputs();
    wb_valid = 0; st_valid = 0; br_valid = 0; trap_valid = 0;
  endtask

  // One clock: collect this cycle's events in age order, advance the model, compare.
  task automatic step(input string tag);
    mrec_t evs[$];
    bit    pop, to_done, has_trap;
    pop      = (mq.size() != 0) && rec_ready;
    to_done  = mhalt && !mdone && (mq.size() == 0);
    has_trap = 0;
    if (!mhalt) begin
      if (wb_valid && wb_rd != 0) evs.push_back(mk(2'd0, wb_pc, wb_instr, wb_data, 0, wb_rd));
      if (st_valid) evs.push_back(mk(2'd1, st_pc, st_instr, st_addr, st_data, 0));
      if (br_valid) evs.push_back(mk(2'd2, br_pc, br_instr, br_next_pc, 0, 0));
      if (trap_valid) evs.push_back(mk(2'd3, trap_pc, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (evs.size() != 0) begin
      if (evs.size() <= DEPTH - mq.size()) begin
        foreach (evs[i]) begin
          evs[i].seq = mseq + SEQW'(i);
          if (evs[i].t == 2'd3) has_trap = 1;
          mq.push_back(evs[i]);
        end
        mseq = mseq + SEQW'(evs.size());
        if (has_trap) mhalt = 1;
      end else begin
        movf = 1;
      end
    end
    if (to_done) mdone = 1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("rst.valid_now", 64'(rec_valid), 64'd0);
    chk("rst.occ_now", 64'(occupancy), 64'd0);
    mq.delete(); mseq = 0; movf = 0; mhalt = 0; mdone = 0;
    check_all("rst");
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic set_wb(input bit [4:0] rd, input bit [31:0] data);
    wb_valid = 1; wb_rd = rd; wb_data = data;
    wb_pc = $urandom; wb_instr = $urandom;
  endtask

  initial begin
    reset_n = 0; rec_ready = 0;
    idle_inputs();
    wb_pc = 0; wb_instr = 0; wb_data = 0; wb_rd = 0;
    st_pc = 0; st_instr = 0; st_addr = 0; st_data = 0;
    br_pc = 0; br_instr = 0; br_next_pc = 0; trap_pc = 0;
    do_reset();

    // Single writeback into an empty FIFO
    set_wb(5'd5, 32'h12); wb_pc = 32'h8000_0000;
    step("s33");
    chk("s33.type", 64'(rec_type), 64'd0);
    chk("s33.rd", 64'(rec_rd), 64'd5);
    chk("s33.f0", 64'(rec_f0), 64'h12);
    chk("s33.seq", 64'(rec_seq), 64'd0);
    idle_inputs();

    // Three same-cycle events with consumer ready
    do_reset();
    rec_ready = 1;
    set_wb(5'd3, $urandom);
    st_valid = 1; st_addr = 32'h100; st_data = 32'hAB; st_pc = $urandom; st_instr = $urandom;
    br_valid = 1; br_next_pc = 32'h8000_0040; br_pc = $urandom; br_instr = $urandom;
    step("s34.push");
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("s34.order_type", 64'(rec_type), 64'(i));
      chk("s34.order_seq", 64'(rec_seq), 64'(i));
      step("s34.pop");
    end

    // Overflow: seven queued, then a two-event cycle is dropped whole
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 7; i++) begin
      set_wb(5'($urandom_range(1, 31)), $urandom);
      step("s35.fill");
    end
    idle_inputs();
    set_wb(5'd9, $urandom);
    st_valid = 1; st_addr = $urandom; st_data = $urandom;
    step("s35.drop");
    chk("s35.occ", 64'(occupancy), 64'd7);
    chk("s35.ovf", 64'(overflow), 64'd1);
    idle_inputs();
    st_valid = 1;
    step("s35.accept");
    idle_inputs();
    rec_ready = 1;
    for (int i = 0; i < 7; i++) step("s35.drain");
    chk("s35.seq7", 64'(rec_seq), 64'd7);
    step("s35.last");

    // Writeback to x0 produces nothing
    rec_ready = 0;
    set_wb(5'd0, $urandom);
    step("s36.x0");
    chk("s36.occ", 64'(occupancy), 64'd0);
    set_wb(5'd1, $urandom);
    step("s36.next");
    chk("s36.seq", 64'(rec_seq), 64'd8);
    idle_inputs();

    // Trap with two queued records, later events ignored, then drain to done
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 2; i++) begin
      set_wb(5'($urandom_range(1, 31)), $urandom);
      step("s37.fill");
    end
    idle_inputs();
    trap_valid = 1; trap_pc = 32'h8000_0080;
    step("s37.trap");
    chk("s37.occ", 64'(occupancy), 64'd3);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      set_wb(5'd7, $urandom); st_valid = 1; trap_valid = 1;
      step("s37.ignored");
    end
    idle_inputs();
    rec_ready = 1;
    for (int i = 0; i < 3; i++) step("s37.drain");
    chk("s37.done_not_yet", 64'(done), 64'd0);
    step("s37.done");
    chk("s37.done", 64'(done), 64'd1);

    // Mid-operation reset discards queued records
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_wb(5'($urandom_range(1, 31)), $urandom);
      step("s38.fill");
    end
    idle_inputs();
    do_reset();
    set_wb(5'd4, $urandom);
    step("s38.after");
    chk("s38.seq", 64'(rec_seq), 64'd0);
    idle_inputs();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (mdone || $urandom_range(0, 299) == 0) do_reset();
      wb_valid = 1'($urandom_range(0, 1)); wb_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wb_pc = $urandom; wb_instr = $urandom; wb_data = $urandom;
      st_valid = 1'($urandom_range(0, 1)); st_pc = $urandom; st_instr = $urandom;
      st_addr = $urandom; st_data = $urandom;
      br_valid = 1'($urandom_range(0, 1)); br_pc = $urandom; br_instr = $urandom;
      br_next_pc = $urandom;
      trap_valid = ($urandom_range(0, 60) == 0); trap_pc = $urandom;
      rec_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/commit_trace_writer.md
COMMIT_TRACE_WRITER -- requirements
Module: commit_trace_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning record FIFO entries (power of 2, minimum 4).
REQ-002 SHALL have parameter SEQW, default 16, meaning the sequence-number width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wb_valid, input, 1, register-writeback commit this cycle.
REQ-006 SHALL have ports wb_pc, wb_instr, wb_data (input, 32) and wb_rd (input, 5), the writeback commit payload.
REQ-007 SHALL have port st_valid, input, 1, store commit this cycle.
REQ-008 SHALL have ports st_pc, st_instr, st_addr, st_data, input, 32, the store payload.
REQ-009 SHALL have port br_valid, input, 1, branch or JALR resolution this cycle.
REQ-010 SHALL have ports br_pc, br_instr, br_next_pc, input, 32, the branch payload (next_pc is the resolved next PC, taken or pc+4).
REQ-011 SHALL have ports trap_valid (input, 1) and trap_pc (input, 32), ECALL/EBREAK committed.
REQ-012 SHALL have port rec_valid, output, 1, FIFO head valid.
REQ-013 SHALL have port rec_ready, input, 1, consumer accepts head.
REQ-014 SHALL have output ports rec_type (2), rec_pc, rec_instr, rec_f0, rec_f1 (32), rec_rd (5) and rec_seq (SEQW), the head record.
REQ-015 SHALL have port occupancy, output, log2(DEPTH)+1, FIFO entries in use.
REQ-016 SHALL have port overflow, output, 1, sticky drop flag.
REQ-017 SHALL have port done, output, 1, trap recorded and FIFO drained.

Function
REQ-018 Record encoding SHALL be: type 0 REG (f0=wb_data, f1=0, rd=wb_rd); type 1 STORE (f0=st_addr, f1=st_data, rd=0); type 2 BRANCH (f0=br_next_pc, f1=0, rd=0); type 3 TRAP (pc=trap_pc, instr/f0/f1/rd=0).
REQ-019 A writeback with wb_rd==0 SHALL be ignored (no record).
REQ-020 Events valid at the same edge SHALL be enqueued in program-age order: REG, STORE, BRANCH, TRAP; up to 4 writes per cycle.
REQ-021 Each enqueued record SHALL receive rec_seq = seq counter + its index within the cycle; counter advances by the number enqueued, modulo 2^SEQW.
REQ-022 If free entries (counting the pop of the same edge) < number of qualifying events, ALL of that cycle's events SHALL be dropped (no partial enqueue), overflow SHALL set, and seq SHALL NOT advance.
REQ-023 Pop SHALL occur at an edge where rec_valid && rec_ready; push and pop in the same edge are permitted, including when full.
REQ-024 Latency: an event enqueued into an empty FIFO at edge N SHALL present rec_valid=1 with its record after edge N.
REQ-025 The head record SHALL remain stable while rec_valid && !rec_ready.
REQ-026 FSM states: RUN, HALT, DONE. RUN→HALT when a TRAP record is enqueued; HALT→DONE when occupancy==0; DONE is terminal until reset.
REQ-027 In HALT and DONE, all input events SHALL be ignored (neither enqueued nor flagged).
REQ-028 A trap_valid that is dropped per REQ-022 SHALL leave the FSM in RUN.
REQ-029 done SHALL be 1 only in DONE.
REQ-030 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH.

Reset
REQ-031 reset_n low SHALL immediately clear the FIFO, occupancy=0, rec_valid=0, overflow=0, done=0, seq=0, state=RUN; record outputs SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued records; the first record after release SHALL carry seq 0.

Verification
REQ-033 Single wb_valid with pc=0x80000000, rd=5, data=0x12 into an empty FIFO -> next cycle rec_valid=1, type 0, rd 5, f0 0x12, seq 0.
REQ-034 Same-cycle wb(rd=3), st(addr=0x100, data=0xAB) and br(next=0x80000040), rec_ready=1 -> three records in order REG, STORE, BRANCH with seq 0, 1, 2.
REQ-035 rec_ready=0, DEPTH=8, seven records queued, then wb+st in one cycle -> both dropped, overflow=1, occupancy stays 7, next accepted record seq 7.
REQ-036 wb_valid with rd=0 -> no record, occupancy unchanged, seq unchanged.
REQ-037 trap_valid at pc 0x80000080 with 2 records queued, then wb_valid events -> TRAP record enqueued, later events ignored, done=1 one cycle after the final pop.
REQ-038 reset_n pulsed low with 4 records queued -> rec_valid=0 and occupancy=0 immediately; next wb record carries seq 0.
